ifetch_mem_responder: RTL
=========================

// Module: ifetch_mem_responder
// PURPOSE
//  Memory-side responder for instruction-cache fills: accepts iREN/iaddr from
//  NCPU icaches, round-robin arbitrates, issues one RAM read at a time, and
//  returns the word on iload with a one-cycle iwait-low strobe. Sits in memory
//  control between the icaches and the RAM port. Yields RAM to pending data
//  accesses (dreq) between transactions.
// PARAMETERS
//  NCPU    2   number of icache requesters
//  ADDR_W  32  address width (word_t address)
//  DATA_W  32  data width (word_t)
// PORTS
//  CLK       in   1             clock, rising edge
//  RST       in   1             reset, asynchronous, active-high
//  iREN      in   NCPU          per-cache fill request, held until served
//  iaddr     in   NCPU*ADDR_W   per-cache fill address, stable while iREN=1
//  iwait     out  NCPU          1=wait; 0 for exactly one cycle = iload valid
//  iload     out  NCPU*DATA_W   fill data, valid only while iwait[i]=0
//  dreq      in   1             data side wants RAM; blocks new ifetch start
//  ibusy     out  1             1 while an ifetch owns RAM (REQ or RESP)
//  ramREN    out  1             RAM read enable
//  ramaddr   out  ADDR_W        RAM address
//  ramload   in   DATA_W        RAM read data, valid when ramstate=ACCESS
//  ramstate  in   2             ramstate_t: FREE, BUSY, ACCESS, ERROR
// BEHAVIOUR
//  Reset (async, RST=1): state=IDLE, iwait='1, iload='0, ramREN=0, ramaddr=0,
//   ibusy=0, winner=0, last_grant=NCPU-1, data_q=0. RST mid-transaction drops
//   ramREN the same instant; the request is not completed.
//  FSM: IDLE -> REQ -> RESP -> IDLE. State and data_q registered; outputs
//   combinational from state, winner, addr_q and data_q.
//  IDLE: ramREN=0, ibusy=0. If dreq=0 and any iREN: winner = first requester
//   after last_grant in ascending order, wrapping NCPU-1 -> 0; latch
//   addr_q=iaddr[winner]; next=REQ. If dreq=1: stay IDLE (data has priority).
//  REQ: ramREN=1, ramaddr=addr_q, ibusy=1. ramstate ACCESS: data_q<=ramload,
//   next=RESP. BUSY/FREE: stay. ERROR: stay, keep ramREN high (retry).
//   iREN[winner] dropping in REQ: abort, next=IDLE, no iwait strobe,
//   last_grant unchanged. dreq rising in REQ: no preemption.
//  RESP: iwait[winner]=0, iload[winner]=data_q for this one cycle; all other
//   iwait=1, other iload=0. ramREN=0, ibusy=1. last_grant<=winner, next=IDLE.
//  iwait[i]=1 and iload[i]=0 at all times except in RESP for i=winner.
//  Latency: iREN seen at cycle N, ACCESS at N+1 earliest -> iwait low N+2.
//   Back-to-back: next grant in the IDLE cycle after RESP (3-cycle minimum
//   period, no bubble beyond IDLE).
//  Simultaneous iREN: round-robin guarantees no requester waits more than
//   NCPU-1 transactions. NCPU=1: winner is always 0.
//  Addresses pass through unmodified; no width conversion.
// TESTING
//  T1 reset: RST=1 mid-REQ -> ramREN=0, iwait=2'b11, iload=0 immediately.
//  T2 single fill: iREN[0]=1, iaddr[0]=0x0000_0040, RAM ACCESS 1 cycle later
//     with ramload=0xDEAD_BEEF -> ramaddr=0x40, iwait[0]=0 at N+2 for one
//     cycle, iload[0]=0xDEAD_BEEF.
//  T3 contention: iREN=2'b11 held, addrs 0x100/0x200 -> grants alternate
//     0,1,0,1; each iwait strobe single-cycle, other iwait stays 1.
//  T4 RAM stall/error: ramstate BUSY x3 then ERROR x2 then ACCESS ->
//     ramREN held high throughout, addr stable, strobe after ACCESS only.
//  T5 dreq: dreq=1 with iREN[1]=1 -> ramREN=0, ibusy=0 until dreq=0; dreq
//     asserted during REQ -> fill still completes.
//  T6 abort: iREN[0] drops in REQ -> IDLE next cycle, no iwait strobe,
//     then iREN[1] pending is granted (last_grant unchanged = 1 -> winner 0
//     absent, so 1).

Source files
------------

// File: rtl/ifetch_mem_responder.sv
// Memory-side responder for icache fills: round-robin picks one requesting icache,
// issues a single RAM read, and returns the word with a one-cycle iwait-low strobe.
module ifetch_mem_responder #(
    parameter int NCPU   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NCPU-1:0]          iREN_i,
    input  logic [NCPU*ADDR_W-1:0]   iaddr_i,
    output logic [NCPU-1:0]          iwait_o,
    output logic [NCPU*DATA_W-1:0]   iload_o,
    input  logic                     dreq_i,
    output logic                     ibusy_o,
    output logic                     ramREN_o,
    output logic [ADDR_W-1:0]        ramaddr_o,
    input  logic [DATA_W-1:0]        ramload_i,
    input  logic [1:0]               ramstate_i
);

    localparam int WIN_W = (NCPU > 1) ? $clog2(NCPU) : 1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t             state_q;
    logic [WIN_W-1:0]   winner_q;
    logic [WIN_W-1:0]   lastGrant_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  data_q;

    logic               grantValid_d;
    logic [WIN_W-1:0]   grantIdx_d;
    logic [ADDR_W-1:0]  grantAddr_d;
    int                 candIdx;

    // Search starts just after the previous winner so every requester is reached
    // within NCPU-1 transactions.
    always_comb begin
        grantValid_d = 1'b0;
        grantIdx_d   = '0;
        candIdx      = 0;
        for (int k = 1; k <= NCPU; k++) begin
            candIdx = (int'(lastGrant_q) + k) % NCPU;
            if (!grantValid_d && iREN_i[candIdx[WIN_W-1:0]]) begin
                grantValid_d = 1'b1;
                grantIdx_d   = candIdx[WIN_W-1:0];
            end
        end
    end

    always_comb begin
        grantAddr_d = '0;
        for (int i = 0; i < NCPU; i++) begin
            if (grantIdx_d == WIN_W'(i)) begin
                grantAddr_d = iaddr_i[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Data-side requests only hold off a new fill; a fill already in REQ runs to completion.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            winner_q    <= '0;
            lastGrant_q <= WIN_W'(NCPU - 1);
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!dreq_i && grantValid_d) begin
                        winner_q <= grantIdx_d;
                        addr_q   <= grantAddr_d;
                        state_q  <= REQ;
                    end
                end
                REQ: begin
                    if (!iREN_i[winner_q]) begin
                        state_q <= IDLE;
                    end else if (ramstate_i == RAM_ACCESS) begin
                        data_q  <= ramload_i;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    lastGrant_q <= winner_q;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        iwait_o = '1;
        iload_o = '0;
        for (int i = 0; i < NCPU; i++) begin
            if (state_q == RESP && winner_q == WIN_W'(i)) begin
                iwait_o[i]                    = 1'b0;
                iload_o[i*DATA_W +: DATA_W]   = data_q;
            end
        end
    end

    assign ramREN_o  = (state_q == REQ);
    assign ramaddr_o = addr_q;
    assign ibusy_o   = (state_q != IDLE);

endmodule
